// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default base address and external SRAM geometry.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Byte address that maps to SRAM word 0.
  localparam logic [31:0] DefaultBaseAddr = 32'd1024;

  // External SRAM: 16-bit data bus, address counted in half-words.
  localparam int unsigned SramDw = 16;
  localparam int unsigned SramAw = 18;

endpackage

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM. Each 32-bit access is split
// into a low and a high half-word transfer, each held for WAIT_CYCLES+1 cycles.
// ready is low while a transfer is in flight; the pipeline freezes on ~ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rd_en, wr_en      load / store request from MEM stage (write wins if both)
//   address           byte address; write_data store data
//   read_data         registered load result, valid from the DONE cycle on
//   ready             1 = no access pending or access complete
//   sram_addr         half-word address; sram_dq_out/sram_dq_oe write data + enable
//   sram_dq_in        read data from SRAM; sram_we_n active-low write strobe
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned SRAM_AW     = SramAw,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SramDw-1:0]  sram_dq_out,
  input  logic [SramDw-1:0]  sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned     NumCyc  = WAIT_CYCLES + 1;
  localparam int unsigned     CntW    = $clog2(NumCyc + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumCyc - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SRAM_AW-2:0]  word_q;
  logic [31:0]         data_q;
  logic                is_wr_q;
  logic [SramDw-1:0]   low_q;
  logic [31:0]         read_data_q;

  logic [31:0]         off;
  logic                req;
  logic                last;

  // Offset wraps modulo 2^32; out-of-range addresses alias by truncation.
  assign off  = address - BASE_ADDR;
  assign req  = rd_en | wr_en;
  assign last = (cnt_q == LastCnt);

  logic unused_off;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          state_d = StLo;
          cnt_d   = '0;
        end
      end
      StLo: begin
        if (last) begin
          state_d = StHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM bus is decoded from state so it is idle in IDLE/DONE and after reset.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state_q == StLo || state_q == StHi) begin
      sram_addr = {word_q, state_q == StHi};
      if (is_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state_q == StHi) ? data_q[31:16] : data_q[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      data_q      <= '0;
      is_wr_q     <= 1'b0;
      low_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        word_q  <= off[SRAM_AW:2];
        data_q  <= write_data;
        is_wr_q <= wr_en;
      end
      // SRAM data is sampled at the end of each half's hold window.
      if (state_q == StLo && last && !is_wr_q) begin
        low_q <= sram_dq_in;
      end
      if (state_q == StHi && last && !is_wr_q) begin
        read_data_q <= {sram_dq_in, low_q};
      end
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench: two controllers (WAIT_CYCLES = 1 and 0) against a word-level
// reference memory; an SRAM bus model stores half-words written over the bus.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        rd_en      [2];
  logic        wr_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] dq_out     [2];
  logic [15:0] dq_in      [2];
  logic        dq_oe      [2];
  logic        we_n       [2];

  sram_mem_ctrl #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_in(dq_in[0]), .sram_dq_oe(dq_oe[0]), .sram_we_n(we_n[0])
  );

  sram_mem_ctrl #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_in(dq_in[1]), .sram_dq_oe(dq_oe[1]), .sram_we_n(we_n[1])
  );

  // Asynchronous SRAM bus model, one half-word array per DUT selected by the top bit.
  logic [15:0] smem [0:(1<<19)-1];
  assign dq_in[0] = smem[{1'b0, sram_addr[0]}];
  assign dq_in[1] = smem[{1'b1, sram_addr[1]}];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!we_n[d] && dq_oe[d]) smem[{d[0], sram_addr[d]}] <= dq_out[d];
    end
  end

  // Reference: 32-bit words keyed by DUT and word index.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd  [2];
  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];
  int chk = 0;
  int err = 0;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  function automatic int key(input int d, input logic [16:0] w);
    return d * (1 << 17) + int'(w);
  endfunction

  function automatic logic [31:0] lookup(input int d, input logic [16:0] w);
    int k;
    k = key(d, w);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      rd_en[d]      = 1'b0;
      wr_en[d]      = 1'b0;
      address[d]    = $urandom;
      write_data[d] = $urandom;
      @(negedge clk);
      check($sformatf("d%0d idle ready", d), 32'(ready[d]), 32'd1);
      check($sformatf("d%0d idle we_n", d), 32'(we_n[d]), 32'd1);
      check($sformatf("d%0d idle oe", d), 32'(dq_oe[d]), 32'd0);
      check($sformatf("d%0d idle read_data", d), read_data[d], exp_rd[d]);
    end
  endtask

  // One full access starting on the next IDLE cycle; inputs are scrambled while busy.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
    int          n;
    logic [16:0] w;
    logic        is_wr;
    n     = (d == 0) ? 2 : 1;
    w     = word_of(addr);
    is_wr = wr;
    @(posedge clk); #1;
    rd_en[d]      = rd;
    wr_en[d]      = wr;
    address[d]    = addr;
    write_data[d] = data;
    if (!is_wr) exp_rd[d] = lookup(d, w);
    @(negedge clk);
    check($sformatf("d%0d req ready", d), 32'(ready[d]), 32'd0);
    for (int k = 1; k <= 2 * n + 1; k++) begin
      @(posedge clk); #1;
      if (k <= 2 * n) begin
        rd_en[d]      = 1'($urandom);
        wr_en[d]      = 1'($urandom);
        address[d]    = $urandom;
        write_data[d] = $urandom;
      end else begin
        rd_en[d] = 1'b0;
        wr_en[d] = 1'b0;
      end
      @(negedge clk);
      if (k <= 2 * n) begin
        check($sformatf("d%0d c%0d ready", d, k), 32'(ready[d]), 32'd0);
        check($sformatf("d%0d c%0d addr", d, k), 32'(sram_addr[d]),
              32'({w, (k > n) ? 1'b1 : 1'b0}));
        check($sformatf("d%0d c%0d we_n", d, k), 32'(we_n[d]), 32'(!is_wr));
        check($sformatf("d%0d c%0d oe", d, k), 32'(dq_oe[d]), 32'(is_wr));
        if (is_wr) begin
          check($sformatf("d%0d c%0d dq", d, k), 32'(dq_out[d]),
                32'((k > n) ? data[31:16] : data[15:0]));
        end
      end else begin
        check($sformatf("d%0d done ready", d), 32'(ready[d]), 32'd1);
        check($sformatf("d%0d done we_n", d), 32'(we_n[d]), 32'd1);
        check($sformatf("d%0d done oe", d), 32'(dq_oe[d]), 32'd0);
        check($sformatf("d%0d done read_data", d), read_data[d], exp_rd[d]);
      end
    end
    if (is_wr) ref_mem[key(d, w)] = data;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int          op;
    for (int d = 0; d < 2; d++) begin
      rst[d]        = 1'b1;
      rd_en[d]      = 1'b0;
      wr_en[d]      = 1'b0;
      address[d]    = '0;
      write_data[d] = '0;
      exp_rd[d]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst ready", d), 32'(ready[d]), 32'd1);
      check($sformatf("d%0d rst we_n", d), 32'(we_n[d]), 32'd1);
      check($sformatf("d%0d rst oe", d), 32'(dq_oe[d]), 32'd0);
      check($sformatf("d%0d rst addr", d), 32'(sram_addr[d]), 32'd0);
      check($sformatf("d%0d rst read_data", d), read_data[d], 32'd0);
    end
    idle(0, 2);
    idle(1, 2);

    // Directed: write, read-back, hold, simultaneous rd/wr, back-to-back reads.
    access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    wq0.push_back(32'd1032);
    access(0, 1'b1, 1'b0, 32'd1032, $urandom);
    idle(0, 2);
    access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
    wq0.push_back(32'd1024);
    idle(0, 1);
    access(0, 1'b1, 1'b0, 32'd1024, $urandom);
    access(0, 1'b1, 1'b0, 32'd1032, $urandom);
    idle(0, 1);

    // Zero wait states, unaligned address maps to word 0.
    access(1, 1'b0, 1'b1, 32'd1027, 32'hCAFEF00D);
    wq1.push_back(32'd1027);
    access(1, 1'b1, 1'b0, 32'd1024, $urandom);
    idle(1, 1);

    // Randomised mix of writes (some aliasing), reads of written words, rd+wr.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        op = $urandom_range(0, 2);
        if (op == 1 && ((d == 0) ? wq0.size() : wq1.size()) != 0) begin
          if (d == 0) a = wq0[$urandom_range(0, wq0.size() - 1)];
          else        a = wq1[$urandom_range(0, wq1.size() - 1)];
          a = a ^ 32'($urandom_range(0, 3));
          access(d, 1'b1, 1'b0, a, $urandom);
        end else begin
          a = ($urandom_range(0, 1) == 0) ? 32'd1024 + 32'($urandom_range(0, 255)) : $urandom;
          v = $urandom;
          access(d, (op == 2) ? 1'b1 : 1'b0, 1'b1, a, v);
          if (d == 0) wq0.push_back(a);
          else        wq1.push_back(a);
        end
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
      end
    end

    // Reset during the HI half of a write: access abandoned, outputs return to idle.
    @(posedge clk); #1;
    wr_en[0]      = 1'b1;
    address[0]    = 32'd5024;
    write_data[0] = 32'hA5A55A5A;
    @(posedge clk); #1;
    wr_en[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("d0 pre-rst hi addr", 32'(sram_addr[0]), 32'd2001);
    check("d0 pre-rst we_n", 32'(we_n[0]), 32'd0);
    #1 rst[0] = 1'b1;
    #1;
    exp_rd[0] = '0;
    check("d0 midrst ready", 32'(ready[0]), 32'd1);
    check("d0 midrst we_n", 32'(we_n[0]), 32'd1);
    check("d0 midrst oe", 32'(dq_oe[0]), 32'd0);
    check("d0 midrst addr", 32'(sram_addr[0]), 32'd0);
    check("d0 midrst read_data", read_data[0], 32'd0);
    #1 rst[0] = 1'b0;
    idle(0, 2);
    access(0, 1'b0, 1'b1, 32'd1040, 32'h0BADC0DE);
    access(0, 1'b1, 1'b0, 32'd1040, $urandom);
    idle(0, 1);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequences MEM-stage data accesses onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two 16-bit transfers, and each transfer is held for a configurable number of wait cycles.
- While a transfer is in progress, the block drives `ready` low. The pipeline uses `~ready` as a global freeze, together with the hazard unit's freeze.
- Placement: between EXE_reg outputs (address, store data, read/write enables) and the MEM_REG inputs (load data).

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM address width, counted in 16-bit half-words.
- WAIT_CYCLES, 1: extra cycles each half-word transfer is held. Per-half duration is N = WAIT_CYCLES+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  load request from the MEM stage.
- wr_en  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (val_rm).
- read_data  out  32  load result, registered.
- ready  out  1  1 = access complete or no access pending. Pipeline freeze = ~ready.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned from SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, counter = 0, read_data = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
  - Latched address, data and op cleared.
  - A reset mid-access abandons the access; no partial write is retried.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en|wr_en is asserted: latch address, write_data and op, then go to LO with counter = 0.
  - If wr_en and rd_en are both asserted, the write wins.
- LO: stay for N cycles, then go to HI with counter reset to 0.
- HI: stay for N cycles, then go to DONE.
- DONE: stays exactly 1 cycle, then returns to IDLE. A request seen in IDLE on the following cycle is treated as a new access.
- ready (combinational):
  - In IDLE: ready = ~(rd_en|wr_en).
  - In DONE: ready = 1.
  - In LO and HI: ready = 0.
- Latency: request first seen in IDLE at cycle 0 → LO occupies cycles 1..N, HI occupies cycles N+1..2N, DONE is cycle 2N+1. With default parameters, ready = 1 at cycle 5.
- Address mapping:
  - off = address - BASE_ADDR, computed with 32-bit unsigned wraparound.
  - word = off[SRAM_AW:2]; bits [1:0] are ignored.
  - LO drives sram_addr = {word, 1'b0}; HI drives sram_addr = {word, 1'b1}.
  - Addresses outside the SRAM range alias by truncation. No error is signalled.
- Write access:
  - During all LO and HI cycles: sram_dq_oe = 1 and sram_we_n = 0.
  - sram_dq_out = data[15:0] in LO, data[31:16] in HI.
  - sram_we_n returns to 1 and sram_dq_oe returns to 0 in DONE and IDLE.
  - read_data is unchanged by a write.
- Read access:
  - sram_we_n = 1 and sram_dq_oe = 0 throughout.
  - On the last cycle of LO, sram_dq_in is captured into a low staging register.
  - On the last cycle of HI, read_data is loaded with {sram_dq_in, low_stage}. It is therefore valid during DONE.
  - read_data holds its value until the next read completes.
- Request inputs may change while ready = 0; the block uses only the values latched in IDLE.
- No-request cycles: ready stays 1 and the SRAM outputs stay idle.
- Counter: width is clog2(N+1). No overflow is possible.

Decomposition:
- Shared package (e.g. arm_defs):
  - State encoding constants: IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3.
  - BASE_ADDR default constant.
  - SRAM width constants: data width 16, address width 18.
- Single module. The wait counter and datapath are too small to justify a sub-module.

Test Plan:
- Reset mid-access: assert rst during HI of a write → next sample shows state IDLE, sram_we_n = 1, sram_dq_oe = 0, read_data = 0, ready = 1 with no request.
- Write: wr_en, address = 32'd1032, write_data = 32'hDEADBEEF, WAIT_CYCLES = 1 → sram_addr = 4 with dq 16'hBEEF for 2 cycles, then sram_addr = 5 with dq 16'hDEAD for 2 cycles, we_n low in all 4 cycles, ready = 1 at cycle 5 only.
- Read-back: rd_en, address = 32'd1032, SRAM model returns the stored halves → read_data = 32'hDEADBEEF in DONE; ready = 0 for cycles 0..4; read_data held after rd_en drops.
- Simultaneous rd_en and wr_en at address 1024 with data 32'h12345678 → write performed at sram_addr 0/1; read_data unchanged.
- Back-to-back: a read request is present on the IDLE cycle immediately after DONE → a new LO starts with no idle gap; ready is low for that cycle.
- WAIT_CYCLES = 0: a write is 1 cycle per half; ready = 1 at cycle 3. An unaligned address 32'd1027 maps to word 0.
